adc_spi_sequencer: RTL and testbench
====================================

ADC_SPI_SEQUENCER -- requirements
Module: adc_spi_sequencer

Interface
REQ-001 Parameter pHALF, default 4, SHALL set the SCLK half-period in clk_usb cycles (legal 1..255).
REQ-002 Parameter pRST_CYCLES, default 16, SHALL set the ADC_RESET pulse width in clk_usb cycles (legal 1..255).
REQ-003 clk_usb  input  1  sole clock; every flop SHALL be clocked on its rising edge.
REQ-004 reset_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  one-cycle request to run one 16-bit serial frame.
REQ-006 rw_i  input  1  frame type: 1 = read, 0 = write; sampled with start_i.
REQ-007 addr_i  input  8  ADC register address; sampled with start_i.
REQ-008 wdata_i  input  8  write data; sampled with start_i; ignored for reads.
REQ-009 rst_req_i  input  1  one-cycle request to pulse ADC_RESET.
REQ-010 busy_o  output  1  high while a frame or reset pulse is in progress.
REQ-011 done_o  output  1  one-cycle pulse when a frame or reset pulse completes.
REQ-012 rdata_o  output  8  data captured by the most recent completed read frame.
REQ-013 ADC_SCLK, ADC_SEN, ADC_SDATA, ADC_RESET  output  1 each  ADC serial-port and reset pins, all registered.
REQ-014 ADC_OVR_SDOUT  input  1  ADC serial data out.

Function
REQ-015 The FSM SHALL have the states IDLE, SETUP, SHIFT, HOLD, ENDF, RSTP and DONE.
REQ-016 In IDLE, outputs SHALL be SEN=1, SCLK=1, SDATA=0, RESET=0, busy_o=0.
REQ-017 A start_i in IDLE SHALL latch rw_i, addr_i and wdata_i into a 16-bit shift word {addr, rw ? 8'h00 : wdata} and enter SETUP on the next cycle.
REQ-018 SETUP SHALL drive SEN=0 and SCLK=1 for pHALF cycles, then enter SHIFT.
REQ-019 SHIFT SHALL send 16 bits MSB-first. Each bit is pHALF cycles with SCLK=1 followed by pHALF cycles with SCLK=0. SDATA SHALL hold the bit for both phases and change only at the start of the high phase.
REQ-020 For reads during bits 8..15, the block SHALL shift ADC_OVR_SDOUT into rdata_shift, MSB-first, on the last cycle of each high phase (the cycle on which SCLK falls next).
REQ-021 After bit 15, HOLD SHALL drive SCLK=1, SDATA=0 and SEN=0 for pHALF cycles. ENDF SHALL then drive SEN=1 for pHALF cycles.
REQ-022 DONE SHALL last exactly one cycle with done_o=1 and busy_o=0. On read frames, DONE SHALL copy rdata_shift to rdata_o; write frames SHALL leave rdata_o unchanged. DONE returns to IDLE.
REQ-023 Frame timing: with start_i accepted at cycle T, busy_o SHALL be 1 for cycles T+1 .. T+35*pHALF, and done_o SHALL be 1 at T+35*pHALF+1.
REQ-024 A rst_req_i in IDLE SHALL enter RSTP, which drives ADC_RESET=1 for pRST_CYCLES cycles with SEN=1, then goes to DONE. RSTP SHALL leave rdata_o unchanged.
REQ-025 start_i and rst_req_i SHALL be ignored whenever the FSM is not in IDLE or DONE. In DONE they SHALL be accepted exactly as in IDLE.
REQ-026 If start_i and rst_req_i arrive together, rst_req_i SHALL win and start_i SHALL be dropped.
REQ-027 The half-period counter SHALL be 8 bits wide and the bit counter 4 bits wide. Neither SHALL wrap inside a phase. The bit counter reaching 15 at the end of a low phase SHALL terminate SHIFT.
REQ-028 pHALF=1 SHALL be supported, giving an SCLK period of 2 clk_usb cycles.

Reset
REQ-029 reset_i SHALL force, on the next clock edge regardless of state: IDLE, SEN=1, SCLK=1, SDATA=0, RESET=0, busy_o=0, done_o=0, rdata_o=0, and all counters and shift registers cleared.
REQ-030 reset_i SHALL override start_i and rst_req_i in the same cycle. A frame aborted by reset SHALL produce no done_o.

Verification
REQ-031 Write test, pHALF=2: write 0xAA to address 0x55. SDATA sampled at each SCLK fall SHALL read 0101_0101_1010_1010. done_o SHALL assert at T+71.
REQ-032 Read test, pHALF=2: read address 0x55 with an ADC model returning 0x3C. SDATA SHALL be 0 during bits 8..15. rdata_o SHALL become 0x3C at done_o.
REQ-033 Busy test: a start_i mid-frame with different addr/data SHALL leave the serial waveform unchanged and SHALL produce exactly one done_o.
REQ-034 Reset test: assert reset_i during bit 5 of a read. Outputs SHALL reach their idle values (SEN=1, SCLK=1, SDATA=0) on the next edge, with rdata_o=0 and no done_o.
REQ-035 Reset-pulse test, pRST_CYCLES=16: after rst_req_i, ADC_RESET SHALL be high for exactly 16 cycles, followed by a single done_o. rst_req_i and start_i together SHALL run only the reset pulse.
REQ-036 Back-to-back test: a start_i issued in the DONE cycle SHALL be accepted, and SEN SHALL fall on the following cycle.

Source files
------------

// File: rtl/adc_spi_sequencer.sv
// ADC serial-port sequencer: runs one 16-bit register frame (write or read)
// over a 3-wire SPI-style port, or pulses the ADC reset pin. All pins and
// status outputs are registered from the next-state decode, so each output
// reflects the FSM state in the same cycle the state is entered.
module adc_spi_sequencer #(
  parameter int pHALF       = 4,
  parameter int pRST_CYCLES = 16
) (
  input  logic       clk_usb,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       rw_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic       rst_req_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       ADC_SCLK,
  output logic       ADC_SEN,
  output logic       ADC_SDATA,
  output logic       ADC_RESET,
  input  logic       ADC_OVR_SDOUT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_ENDF,
    S_RSTP,
    S_DONE
  } state_t;

  // Terminal counts for the shared 8-bit cycle counter.
  localparam logic [7:0] HALF_LAST = 8'(pHALF - 1);
  localparam logic [7:0] RST_LAST  = 8'(pRST_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  half_cnt_q, half_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        phase_low_q, phase_low_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  rdata_shift_q, rdata_shift_d;
  logic        rw_q, rw_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        sclk_q, sclk_d;
  logic        sen_q, sen_d;
  logic        sdata_q, sdata_d;
  logic        rst_pin_q, rst_pin_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        half_last;

  assign half_last = (half_cnt_q == HALF_LAST);

  // Next-state logic plus registered-output decode from the next state.
  always_comb begin
    state_d       = state_q;
    half_cnt_d    = half_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    phase_low_d   = phase_low_q;
    shift_d       = shift_q;
    rdata_shift_d = rdata_shift_q;
    rw_d          = rw_q;
    rdata_d       = rdata_q;

    case (state_q)
      // DONE behaves like IDLE for new requests; reset pulse beats a frame.
      S_IDLE, S_DONE: begin
        state_d    = S_IDLE;
        half_cnt_d = '0;
        if (rst_req_i) begin
          state_d = S_RSTP;
        end else if (start_i) begin
          state_d       = S_SETUP;
          rw_d          = rw_i;
          shift_d       = {addr_i, (rw_i ? 8'h00 : wdata_i)};
          bit_cnt_d     = '0;
          phase_low_d   = 1'b0;
          rdata_shift_d = '0;
        end
      end
      S_SETUP: begin
        if (half_last) begin
          state_d     = S_SHIFT;
          half_cnt_d  = '0;
          bit_cnt_d   = '0;
          phase_low_d = 1'b0;
        end else begin
          half_cnt_d = half_cnt_q + 8'd1;
        end
      end
      S_SHIFT: begin
        if (!half_last) begin
          half_cnt_d = half_cnt_q + 8'd1;
        end else begin
          half_cnt_d = '0;
          if (!phase_low_q) begin
            // Last high cycle: capture read data for the second byte.
            phase_low_d = 1'b1;
            if (rw_q && bit_cnt_q[3]) begin
              rdata_shift_d = {rdata_shift_q[6:0], ADC_OVR_SDOUT};
            end
          end else if (bit_cnt_q == 4'd15) begin
            state_d     = S_HOLD;
            phase_low_d = 1'b0;
          end else begin
            // Next bit presented at the start of its high phase.
            bit_cnt_d   = bit_cnt_q + 4'd1;
            phase_low_d = 1'b0;
            shift_d     = {shift_q[14:0], 1'b0};
          end
        end
      end
      S_HOLD: begin
        if (half_last) begin
          state_d    = S_ENDF;
          half_cnt_d = '0;
        end else begin
          half_cnt_d = half_cnt_q + 8'd1;
        end
      end
      S_ENDF: begin
        if (half_last) begin
          state_d    = S_DONE;
          half_cnt_d = '0;
          if (rw_q) begin
            rdata_d = rdata_shift_q;
          end
        end else begin
          half_cnt_d = half_cnt_q + 8'd1;
        end
      end
      S_RSTP: begin
        if (half_cnt_q == RST_LAST) begin
          state_d    = S_DONE;
          half_cnt_d = '0;
        end else begin
          half_cnt_d = half_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        half_cnt_d = '0;
      end
    endcase

    sen_d     = !(state_d == S_SETUP || state_d == S_SHIFT || state_d == S_HOLD);
    sclk_d    = !(state_d == S_SHIFT && phase_low_d);
    sdata_d   = (state_d == S_SHIFT) && shift_d[15];
    rst_pin_d = (state_d == S_RSTP);
    busy_d    = !(state_d == S_IDLE || state_d == S_DONE);
    done_d    = (state_d == S_DONE);
  end

  // State, datapath and output registers with synchronous reset to idle.
  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      half_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      phase_low_q   <= 1'b0;
      shift_q       <= '0;
      rdata_shift_q <= '0;
      rw_q          <= 1'b0;
      rdata_q       <= '0;
      sclk_q        <= 1'b1;
      sen_q         <= 1'b1;
      sdata_q       <= 1'b0;
      rst_pin_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      half_cnt_q    <= half_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      phase_low_q   <= phase_low_d;
      shift_q       <= shift_d;
      rdata_shift_q <= rdata_shift_d;
      rw_q          <= rw_d;
      rdata_q       <= rdata_d;
      sclk_q        <= sclk_d;
      sen_q         <= sen_d;
      sdata_q       <= sdata_d;
      rst_pin_q     <= rst_pin_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign ADC_SCLK  = sclk_q;
  assign ADC_SEN   = sen_q;
  assign ADC_SDATA = sdata_q;
  assign ADC_RESET = rst_pin_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Bench for adc_spi_sequencer: a pin-level ADC model plus a frame-level
// reference (expected bit word, completion cycle, read-back byte).
module tb_adc_spi_sequencer;

  localparam int H = 2;
  localparam int R = 16;

  logic       clk_usb = 1'b0;
  logic       reset_i, start_i, rw_i, rst_req_i;
  logic [7:0] addr_i, wdata_i;
  logic       busy_o, done_o;
  logic [7:0] rdata_o;
  logic       ADC_SCLK, ADC_SEN, ADC_SDATA, ADC_RESET, ADC_OVR_SDOUT;

  always #5 clk_usb = ~clk_usb;

  adc_spi_sequencer #(.pHALF(H), .pRST_CYCLES(R)) dut (
    .clk_usb(clk_usb), .reset_i(reset_i), .start_i(start_i), .rw_i(rw_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rst_req_i(rst_req_i),
    .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
    .ADC_SCLK(ADC_SCLK), .ADC_SEN(ADC_SEN), .ADC_SDATA(ADC_SDATA),
    .ADC_RESET(ADC_RESET), .ADC_OVR_SDOUT(ADC_OVR_SDOUT)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [7:0] exp_rdata = 8'h00;
  logic [7:0] adc_byte = 8'h00;

  always @(posedge clk_usb) cyc <= cyc + 1;

  // Pin monitor / ADC model state, sampled mid-cycle.
  bit sdata_bits[$];
  int frame_falls = 0, falls_total = 0, glitch_total = 0, done_total = 0;
  int busy_total = 0, rst_total = 0, sen_low_total = 0, sen_fall_cyc = -1;
  logic sclk_prev = 1'b1, sen_prev = 1'b1, sdata_prev = 1'b0;

  // ADC drives the second byte, bit k valid during the high phase of bit k.
  assign ADC_OVR_SDOUT = (frame_falls >= 8 && frame_falls <= 15) ?
                         adc_byte[3'(15 - frame_falls)] : 1'b0;

  always @(negedge clk_usb) begin
    if (ADC_SEN) begin
      frame_falls <= 0;
    end else if (sclk_prev && !ADC_SCLK) begin
      sdata_bits.push_back(ADC_SDATA);
      frame_falls <= frame_falls + 1;
      falls_total <= falls_total + 1;
    end
    if (!sclk_prev && !ADC_SCLK && ADC_SDATA != sdata_prev) glitch_total <= glitch_total + 1;
    if (done_o) done_total <= done_total + 1;
    if (busy_o) busy_total <= busy_total + 1;
    if (ADC_RESET) rst_total <= rst_total + 1;
    if (!ADC_SEN) sen_low_total <= sen_low_total + 1;
    if (sen_prev && !ADC_SEN) sen_fall_cyc <= cyc;
    sclk_prev  <= ADC_SCLK;
    sen_prev   <= ADC_SEN;
    sdata_prev <= ADC_SDATA;
  end

  task automatic tick();
    @(posedge clk_usb);
    #1;
  endtask

  task automatic drive(input bit st, input bit rst, input bit rw,
                       input logic [7:0] a, input logic [7:0] w, output int t);
    start_i = st; rst_req_i = rst; rw_i = rw; addr_i = a; wdata_i = w;
    t = cyc;
    tick();
    start_i = 1'b0; rst_req_i = 1'b0;
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int i = 0; i < 400; i++) begin
      if (done_o) begin
        d = cyc;
        break;
      end
      tick();
    end
  endtask

  function automatic logic [15:0] word_at(input int base);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      if (base + i < sdata_bits.size()) w = {w[14:0], sdata_bits[base + i]};
      else w = {w[14:0], 1'b0};
    end
    return w;
  endfunction

  task automatic test_reset();
    reset_i = 1'b1; start_i = 1'b1; rst_req_i = 1'b1; rw_i = 1'b0;
    addr_i = 8'h12; wdata_i = 8'h34;
    repeat (3) tick();
    start_i = 1'b0; rst_req_i = 1'b0; reset_i = 1'b0;
    exp_rdata = 8'h00;
    compared++;
    if ({ADC_SEN, ADC_SCLK, ADC_SDATA, ADC_RESET} !== 4'b1100) begin
      mismatched++; $display("FAIL reset_pins got %b want 1100", {ADC_SEN, ADC_SCLK, ADC_SDATA, ADC_RESET});
    end
    compared++;
    if ({busy_o, done_o, rdata_o} !== 10'h000) begin
      mismatched++; $display("FAIL reset_status got busy=%b done=%b rdata=%h want 0/0/00", busy_o, done_o, rdata_o);
    end
    repeat (3) tick();
    compared++;
    if (busy_o !== 1'b0) begin
      mismatched++; $display("FAIL reset_override busy got %b want 0", busy_o);
    end
  endtask

  task automatic run_frame_check(input string nm, input bit rw, input logic [7:0] a,
                                 input logic [7:0] w, input logic [7:0] adc);
    int t, d, b0, bz, g0, n0;
    logic [15:0] exp_word;
    adc_byte = adc;
    exp_word = {a, (rw ? 8'h00 : w)};
    if (rw) exp_rdata = adc;
    b0 = sdata_bits.size(); bz = busy_total; g0 = glitch_total; n0 = done_total;
    drive(1'b1, 1'b0, rw, a, w, t);
    wait_done(d);
    compared++;
    if (word_at(b0) !== exp_word || sdata_bits.size() - b0 != 16) begin
      mismatched++; $display("FAIL %s_sdata got %h (%0d bits) want %h (16 bits)", nm, word_at(b0), sdata_bits.size() - b0, exp_word);
    end
    compared++;
    if (d !== t + 35 * H + 1) begin
      mismatched++; $display("FAIL %s_done_cycle got %0d want %0d", nm, d, t + 35 * H + 1);
    end
    compared++;
    if (rdata_o !== exp_rdata) begin
      mismatched++; $display("FAIL %s_rdata got %h want %h", nm, rdata_o, exp_rdata);
    end
    compared++;
    if (busy_total - bz != 35 * H || glitch_total != g0) begin
      mismatched++; $display("FAIL %s_busy_glitch got busy=%0d glitches=%0d want %0d/0", nm, busy_total - bz, glitch_total - g0, 35 * H);
    end
    repeat (3) tick();
    compared++;
    if (done_total - n0 != 1) begin
      mismatched++; $display("FAIL %s_done_count got %0d want 1", nm, done_total - n0);
    end
  endtask

  task automatic test_write();
    run_frame_check("write", 1'b0, 8'h55, 8'hAA, 8'hFF);
  endtask

  task automatic test_read();
    run_frame_check("read", 1'b1, 8'h55, 8'hC3, 8'h3C);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      run_frame_check("random", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    int t, n0, s0;
    bit found;
    adc_byte = 8'hA5;
    drive(1'b1, 1'b0, 1'b1, 8'h81, 8'h00, t);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (frame_falls == 5 && ADC_SCLK) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    compared++;
    if (!found) begin
      mismatched++; $display("FAIL resetmid_reach_bit5 got timeout want bit 5");
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    exp_rdata = 8'h00;
    compared++;
    if ({ADC_SEN, ADC_SCLK, ADC_SDATA} !== 3'b110 || busy_o !== 1'b0) begin
      mismatched++; $display("FAIL resetmid_pins got sen/sclk/sdata=%b busy=%b want 110/0", {ADC_SEN, ADC_SCLK, ADC_SDATA}, busy_o);
    end
    compared++;
    if (rdata_o !== exp_rdata) begin
      mismatched++; $display("FAIL resetmid_rdata got %h want %h", rdata_o, exp_rdata);
    end
    n0 = done_total; s0 = sen_low_total;
    repeat (120) tick();
    compared++;
    if (done_total != n0 || sen_low_total != s0) begin
      mismatched++; $display("FAIL resetmid_no_done got done=%0d senlow=%0d want 0/0", done_total - n0, sen_low_total - s0);
    end
  endtask

  task automatic test_busy();
    int t, tx, d, b0, n0, r0;
    logic [15:0] exp_word;
    adc_byte = 8'h00;
    exp_word = {8'h3A, 8'h6E};
    b0 = sdata_bits.size(); n0 = done_total; r0 = rst_total;
    drive(1'b1, 1'b0, 1'b0, 8'h3A, 8'h6E, t);
    repeat (30) tick();
    drive(1'b1, 1'b0, 1'b1, 8'hC5, 8'h91, tx);
    repeat (10) tick();
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, tx);
    wait_done(d);
    repeat (5) tick();
    compared++;
    if (word_at(b0) !== exp_word || sdata_bits.size() - b0 != 16) begin
      mismatched++; $display("FAIL busy_sdata got %h (%0d bits) want %h", word_at(b0), sdata_bits.size() - b0, exp_word);
    end
    compared++;
    if (d !== t + 35 * H + 1 || done_total - n0 != 1) begin
      mismatched++; $display("FAIL busy_done got cycle=%0d count=%0d want %0d/1", d, done_total - n0, t + 35 * H + 1);
    end
    compared++;
    if (rst_total != r0) begin
      mismatched++; $display("FAIL busy_rstreq_ignored got %0d reset cycles want 0", rst_total - r0);
    end
  endtask

  task automatic test_rst_pulse();
    int t, d, n0, r0, f0, s0;
    for (int k = 0; k < 2; k++) begin
      n0 = done_total; r0 = rst_total; f0 = falls_total; s0 = sen_low_total;
      adc_byte = 8'h77;
      drive(k == 1, 1'b1, 1'b1, 8'h0F, 8'hF0, t);
      wait_done(d);
      compared++;
      if (rst_total - r0 != R || d !== t + R + 1) begin
        mismatched++; $display("FAIL rstpulse%0d_width got %0d cycles done@%0d want %0d done@%0d", k, rst_total - r0, d, R, t + R + 1);
      end
      repeat (3) tick();
      compared++;
      if (done_total - n0 != 1 || falls_total != f0 || sen_low_total != s0) begin
        mismatched++; $display("FAIL rstpulse%0d_only got done=%0d falls=%0d senlow=%0d want 1/0/0", k, done_total - n0, falls_total - f0, sen_low_total - s0);
      end
      compared++;
      if (rdata_o !== exp_rdata) begin
        mismatched++; $display("FAIL rstpulse%0d_rdata got %h want %h", k, rdata_o, exp_rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t, d, t2, d2, b0;
    logic [15:0] wa, wb;
    adc_byte = 8'h5A;
    wa = {8'hE1, 8'h2D};
    wb = {8'h4B, 8'h00};
    b0 = sdata_bits.size();
    drive(1'b1, 1'b0, 1'b0, 8'hE1, 8'h2D, t);
    wait_done(d);
    drive(1'b1, 1'b0, 1'b1, 8'h4B, 8'h99, t2);
    exp_rdata = 8'h5A;
    wait_done(d2);
    compared++;
    if (sen_fall_cyc !== d + 1 || t2 !== d) begin
      mismatched++; $display("FAIL b2b_sen_fall got %0d want %0d", sen_fall_cyc, d + 1);
    end
    compared++;
    if (word_at(b0) !== wa || word_at(b0 + 16) !== wb) begin
      mismatched++; $display("FAIL b2b_sdata got %h,%h want %h,%h", word_at(b0), word_at(b0 + 16), wa, wb);
    end
    compared++;
    if (d2 !== d + 35 * H + 1 || rdata_o !== exp_rdata) begin
      mismatched++; $display("FAIL b2b_second got done@%0d rdata=%h want %0d/%h", d2, rdata_o, d + 35 * H + 1, exp_rdata);
    end
  endtask

  initial begin
    reset_i = 1'b1; start_i = 1'b0; rst_req_i = 1'b0; rw_i = 1'b0;
    addr_i = 8'h00; wdata_i = 8'h00;
    tick();
    test_reset();
    test_write();
    test_read();
    test_reset_mid();
    test_random();
    test_busy();
    test_rst_pulse();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
